// File: rtl/sqrt_digit_seq.sv
// Iterative integer square root (one root bit per clock) followed by a
// tens / units / blank digit sequencer feeding a 7-segment decoder.
module sqrt_digit_seq #(
   parameter int WIDTH = 8,
   parameter int DWELL = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   operand,
   output logic [3:0]         digit,
   output logic [WIDTH/2-1:0] root,
   output logic               busy,
   output logic               valid
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;
   localparam int CW = $clog2(HW + 1);
   localparam int DW = $clog2(DWELL + 1);

   typedef enum logic [2:0] {IDLE, CALC, TENS, UNITS, GAP} state_t;

   state_t          state, state_next;
   logic [WIDTH-1:0] opnd;
   logic [RW-1:0]    rem, rem_shift, rem_new, trial;
   logic [HW-1:0]    partial, partial_new, root_next;
   logic [CW-1:0]    count;
   logic [DW-1:0]    dwell;
   logic             last_iter, dwell_done, load;
   logic [3:0]       digit_next, root4, units;
   logic             busy_next, valid_next;

   assign last_iter  = (state == CALC) && (count == CW'(1));
   assign dwell_done = (dwell == DW'(DWELL - 1));
   assign load       = start && (state != CALC);

   // One restoring square-root step on the next operand bit pair.
   always_comb begin
      rem_shift   = {rem[RW-3:0], opnd[WIDTH-1 -: 2]};
      trial       = {partial, 2'b01};
      rem_new     = rem_shift;
      partial_new = partial << 1;
      if (rem_shift >= trial) begin
         rem_new     = rem_shift - trial;
         partial_new = (partial << 1) | HW'(1);
      end
      root_next = last_iter ? partial_new : root;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = CALC;
         CALC:  if (last_iter) state_next = TENS;
         TENS:  if (start) state_next = CALC; else if (dwell_done) state_next = UNITS;
         UNITS: if (start) state_next = CALC; else if (dwell_done) state_next = GAP;
         GAP:   if (start) state_next = CALC; else if (dwell_done) state_next = TENS;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are precomputed from the upcoming state so that they can be registered.
   always_comb begin
      root4      = 4'(root_next);
      units      = (root4 >= 4'd10) ? (root4 - 4'd10) : root4;
      digit_next = 4'hF;
      case (state_next)
         TENS:    digit_next = (root4 >= 4'd10) ? 4'd1 : 4'hF;
         UNITS:   digit_next = units;
         default: digit_next = 4'hF;
      endcase
      busy_next  = (state_next == CALC);
      valid_next = (state_next == TENS) || (state_next == UNITS) || (state_next == GAP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opnd    <= '0;
         rem     <= '0;
         partial <= '0;
         count   <= '0;
         dwell   <= '0;
         root    <= '0;
         digit   <= 4'hF;
         busy    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         if (load) begin
            opnd    <= operand;
            rem     <= '0;
            partial <= '0;
            count   <= CW'(HW);
         end else if (state == CALC) begin
            opnd    <= opnd << 2;
            rem     <= rem_new;
            partial <= partial_new;
            count   <= count - CW'(1);
         end
         // The dwell counter restarts whenever a display slot is entered.
         if (valid_next && (state_next == state)) dwell <= dwell + DW'(1);
         else                                      dwell <= '0;
         root  <= root_next;
         digit <= digit_next;
         busy  <= busy_next;
         valid <= valid_next;
      end
   end

endmodule

// File: tb/tb_sqrt_digit_seq.sv
// Self-checking bench for sqrt_digit_seq: vector table, directed corner
// sequences and random operands against an arithmetic reference model.
module tb_sqrt_digit_seq;

   localparam int WIDTH = 8;
   localparam int DWELL = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] operand = '0;
   logic [3:0] digit;
   logic [3:0] root;
   logic       busy;
   logic       valid;

   int n_compared = 0;
   int n_mismatched = 0;

   typedef struct {
      logic [7:0] op;
      logic [3:0] exp_root;
      logic [3:0] exp_tens;
      logic [3:0] exp_units;
   } vec_t;

   vec_t vecs[6];

   sqrt_digit_seq #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .operand(operand),
      .digit(digit),
      .root(root),
      .busy(busy),
      .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller sits just after the edge that entered TENS.
   task automatic check_display(input logic [3:0] tens, input logic [3:0] units, input int cycles);
      logic [3:0] exp;
      for (int t = 0; t < cycles; t++) begin
         case ((t / DWELL) % 3)
            0:       exp = tens;
            1:       exp = units;
            default: exp = 4'hF;
         endcase
         check_output("display_digit", 16'(digit), 16'(exp));
         check_output("display_valid", 16'(valid), 16'd1);
         tick();
      end
   endtask

   // Pulses start and waits for the result; returns just after the finishing edge.
   task automatic apply_stimulus(input logic [7:0] op, input logic [3:0] exp_root);
      int n;
      operand = op;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_output("start_digit_blank", 16'(digit), 16'hF);
      check_output("start_valid_low", 16'(valid), 16'd0);
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
      check_output("busy_cycles", 16'(n), 16'd4);
      check_output("done_valid", 16'(valid), 16'd1);
      check_output("done_root", 16'(root), 16'(exp_root));
   endtask

   task automatic run_model(input logic [7:0] op, input int cycles);
      int r;
      logic [3:0] t, u;
      r = isqrt(int'(op));
      t = (r >= 10) ? 4'd1 : 4'hF;
      u = 4'(r % 10);
      apply_stimulus(op, 4'(r));
      check_display(t, u, cycles);
   endtask

   initial begin
      vecs[0] = '{8'd0,   4'd0,  4'hF, 4'd0};
      vecs[1] = '{8'd255, 4'd15, 4'd1, 4'd5};
      vecs[2] = '{8'd99,  4'd9,  4'hF, 4'd9};
      vecs[3] = '{8'd100, 4'd10, 4'd1, 4'd0};
      vecs[4] = '{8'd120, 4'd10, 4'd1, 4'd0};
      vecs[5] = '{8'd16,  4'd4,  4'hF, 4'd4};

      repeat (3) tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_output("idle_digit", 16'(digit), 16'hF);
         check_output("idle_root", 16'(root), 16'd0);
         check_output("idle_busy", 16'(busy), 16'd0);
         check_output("idle_valid", 16'(valid), 16'd0);
         tick();
      end

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i].op, vecs[i].exp_root);
         check_display(vecs[i].exp_tens, vecs[i].exp_units, 3 * DWELL * 2);
      end

      // start pulsed during CALC must be ignored
      operand = 8'd16;
      start = 1'b1;
      tick();
      operand = 8'd48;
      tick();
      tick();
      start = 1'b0;
      repeat (2) tick();
      check_output("ignore_root", 16'(root), 16'd4);
      check_output("ignore_valid", 16'(valid), 16'd1);
      check_output("ignore_busy", 16'(busy), 16'd0);

      // restart from the UNITS slot
      repeat (DWELL) tick();
      check_output("units_digit", 16'(digit), 16'd4);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_output("restart_valid", 16'(valid), 16'd0);
      check_output("restart_digit", 16'(digit), 16'hF);
      check_output("restart_busy", 16'(busy), 16'd1);
      for (int i = 0; i < 4; i++) begin
         check_output("restart_root_hold", 16'(root), 16'd4);
         tick();
      end
      check_output("restart_root_new", 16'(root), 16'd6);
      check_output("restart_busy_low", 16'(busy), 16'd0);
      check_display(4'hF, 4'd6, 3 * DWELL);

      // reset in the second CALC cycle, with start held to test priority
      operand = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check_output("rst_busy", 16'(busy), 16'd0);
      check_output("rst_valid", 16'(valid), 16'd0);
      check_output("rst_digit", 16'(digit), 16'hF);
      check_output("rst_root", 16'(root), 16'd0);
      tick();
      check_output("rst_idle_busy", 16'(busy), 16'd0);
      apply_stimulus(8'd200, 4'd14);
      check_display(4'd1, 4'd4, 3 * DWELL);

      for (int i = 0; i < 20; i++) begin
         run_model(8'($urandom_range(0, 255)), 3 * DWELL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
